// File: rtl/mem_access_pkg.sv
// mem_access_pkg: op codes, FSM state encoding and lane helpers for the MEM stage
package mem_access_pkg;

    localparam logic [7:0] EXE_NOP_OP  = 8'b00000000;
    localparam logic [7:0] EXE_ADDU_OP = 8'b00100001;
    localparam logic [7:0] EXE_LB_OP   = 8'b11100000;
    localparam logic [7:0] EXE_LBU_OP  = 8'b11100100;
    localparam logic [7:0] EXE_LH_OP   = 8'b11100001;
    localparam logic [7:0] EXE_LHU_OP  = 8'b11100101;
    localparam logic [7:0] EXE_LW_OP   = 8'b11100011;
    localparam logic [7:0] EXE_SB_OP   = 8'b11101000;
    localparam logic [7:0] EXE_SH_OP   = 8'b11101001;
    localparam logic [7:0] EXE_SW_OP   = 8'b11101011;

    typedef enum logic [1:0] {
        MEM_ST_IDLE = 2'b00,
        MEM_ST_BUSY = 2'b01,
        MEM_ST_DONE = 2'b10
    } mem_st_e;

    function automatic logic is_load(input logic [7:0] op);
        return op inside {EXE_LB_OP, EXE_LBU_OP, EXE_LH_OP, EXE_LHU_OP, EXE_LW_OP};
    endfunction

    function automatic logic is_store(input logic [7:0] op);
        return op inside {EXE_SB_OP, EXE_SH_OP, EXE_SW_OP};
    endfunction

    function automatic logic misaligned(input logic [7:0] op, input logic [1:0] a);
        return (op inside {EXE_LH_OP, EXE_LHU_OP, EXE_SH_OP} && a[0]) ||
               (op inside {EXE_LW_OP, EXE_SW_OP} && a != 2'b00);
    endfunction

    // Big-endian lanes: byte 0 of the word lives on sel[3] / bits 31:24
    function automatic logic [3:0] lane_sel(input logic [7:0] op, input logic [1:0] a);
        return (op inside {EXE_LB_OP, EXE_LBU_OP, EXE_SB_OP}) ? 4'b1000 >> a :
               (op inside {EXE_LH_OP, EXE_LHU_OP, EXE_SH_OP}) ? (a[1] ? 4'b0011 : 4'b1100) :
               4'b1111;
    endfunction

    function automatic logic [31:0] store_data(input logic [7:0] op, input logic [31:0] d);
        return (op == EXE_SB_OP) ? {4{d[7:0]}} : (op == EXE_SH_OP) ? {2{d[15:0]}} : d;
    endfunction

endpackage

// File: rtl/mem_access_load_align.sv
// mem_access_load_align: picks the addressed byte/half of a bus word and sign/zero-extends it
module mem_access_load_align
    import mem_access_pkg::*;
(
    input  logic [7:0]  aluop_i,
    input  logic [1:0]  addr_i,
    input  logic [31:0] rdata_i,
    output logic [31:0] result_o
);

    logic [7:0]  byte_w;
    logic [15:0] half_w;

    // Lane select then extension; addr[0] is don't-care for halves
    always_comb begin
        byte_w   = addr_i[1] ? (addr_i[0] ? rdata_i[7:0] : rdata_i[15:8])
                             : (addr_i[0] ? rdata_i[23:16] : rdata_i[31:24]);
        half_w   = addr_i[1] ? rdata_i[15:0] : rdata_i[31:16];
        result_o = (aluop_i == EXE_LB_OP)  ? {{24{byte_w[7]}}, byte_w} :
                   (aluop_i == EXE_LBU_OP) ? {24'b0, byte_w} :
                   (aluop_i == EXE_LH_OP)  ? {{16{half_w[15]}}, half_w} :
                   (aluop_i == EXE_LHU_OP) ? {16'b0, half_w} :
                   rdata_i;
    end

endmodule

// File: rtl/mem_access.sv
// mem_access: MEM stage, runs loads/stores over a req/ack bus and stalls the pipe until done.
// Optional MEM_ALIGN_CHECK_EN adds addr_err_o and rejects misaligned half/word accesses.
module mem_access
    import mem_access_pkg::*;
#(
    parameter int unsigned BUS_TIMEOUT = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  mem_wd_i,
    input  logic        mem_wreg_i,
    input  logic [31:0] mem_wdata_i,
    input  logic [7:0]  mem_aluop_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_reg2_i,
    input  logic        bus_ack_i,
    input  logic [31:0] bus_rdata_i,
    output logic [4:0]  wd_o,
    output logic        wreg_o,
    output logic [31:0] wdata_o,
    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [31:0] bus_addr_o,
    output logic [3:0]  bus_sel_o,
    output logic [31:0] bus_wdata_o,
    output logic        stallreq_o,
`ifdef MEM_ALIGN_CHECK_EN
    output logic        addr_err_o,
`endif
    output logic        bus_err_o
);

    mem_st_e     state_q, state_d;
    logic        bus_req_q, bus_req_d, bus_we_q, bus_we_d;
    logic [31:0] bus_addr_q, bus_addr_d, bus_wdata_q, bus_wdata_d;
    logic [3:0]  bus_sel_q, bus_sel_d;
    logic [7:0]  op_q, op_d;
    logic [1:0]  lo_q, lo_d;
    logic [4:0]  wd_q, wd_d;
    logic        wreg_q, wreg_d;
    logic [31:0] cap_q, cap_d, cnt_q, cnt_d;
    logic [31:0] ld_res;
    logic        mis, go, idle, timeout_hit;

`ifdef MEM_ALIGN_CHECK_EN
    assign mis        = misaligned(mem_aluop_i, mem_addr_i[1:0]);
    assign addr_err_o = idle && mis;
`else
    assign mis = 1'b0;
`endif

    assign idle        = state_q == MEM_ST_IDLE;
    assign go          = idle && (is_load(mem_aluop_i) || is_store(mem_aluop_i)) && !mis;
    assign timeout_hit = (BUS_TIMEOUT != 0) && (cnt_q == 32'(BUS_TIMEOUT - 1));

    mem_access_load_align u_align (
        .aluop_i  (op_q),
        .addr_i   (lo_q),
        .rdata_i  (cap_q),
        .result_o (ld_res)
    );

    // Write-back: pass-through in IDLE, captured instruction afterwards; loads write only in DONE
    assign wd_o    = idle ? mem_wd_i : wd_q;
    assign wdata_o = idle ? mem_wdata_i : ld_res;
    assign wreg_o  = idle ? (mem_wreg_i && !is_load(mem_aluop_i) && !is_store(mem_aluop_i))
                          : (state_q == MEM_ST_DONE && is_load(op_q) && wreg_q);

    assign bus_req_o   = bus_req_q;
    assign bus_we_o    = bus_we_q;
    assign bus_addr_o  = bus_addr_q;
    assign bus_sel_o   = bus_sel_q;
    assign bus_wdata_o = bus_wdata_q;

    // Next-state, bus field capture and stall/error outputs; ack beats timeout
    always_comb begin
        state_d     = state_q;
        bus_req_d   = bus_req_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_sel_d   = bus_sel_q;
        bus_wdata_d = bus_wdata_q;
        op_d        = op_q;
        lo_d        = lo_q;
        wd_d        = wd_q;
        wreg_d      = wreg_q;
        cap_d       = cap_q;
        cnt_d       = cnt_q;
        stallreq_o  = 1'b0;
        bus_err_o   = 1'b0;
        case (state_q)
            MEM_ST_IDLE: begin
                if (go) begin
                    stallreq_o  = 1'b1;
                    state_d     = MEM_ST_BUSY;
                    bus_req_d   = 1'b1;
                    bus_we_d    = is_store(mem_aluop_i);
                    bus_addr_d  = {mem_addr_i[31:2], 2'b00};
                    bus_sel_d   = lane_sel(mem_aluop_i, mem_addr_i[1:0]);
                    bus_wdata_d = is_store(mem_aluop_i) ? store_data(mem_aluop_i, mem_reg2_i) : 32'b0;
                    op_d        = mem_aluop_i;
                    lo_d        = mem_addr_i[1:0];
                    wd_d        = mem_wd_i;
                    wreg_d      = mem_wreg_i;
                    cnt_d       = 32'b0;
                end
            end
            MEM_ST_BUSY: begin
                stallreq_o = 1'b1;
                if (bus_ack_i) begin
                    cap_d     = bus_rdata_i;
                    bus_req_d = 1'b0;
                    state_d   = MEM_ST_DONE;
                end else if (timeout_hit) begin
                    cap_d     = 32'b0;
                    bus_req_d = 1'b0;
                    bus_err_o = 1'b1;
                    state_d   = MEM_ST_DONE;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            default: state_d = MEM_ST_IDLE;
        endcase
    end

    // State and capture registers, cleared by active-low synchronous reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= MEM_ST_IDLE;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= 32'b0;
            bus_sel_q   <= 4'b0;
            bus_wdata_q <= 32'b0;
            op_q        <= 8'b0;
            lo_q        <= 2'b0;
            wd_q        <= 5'b0;
            wreg_q      <= 1'b0;
            cap_q       <= 32'b0;
            cnt_q       <= 32'b0;
        end else begin
            state_q     <= state_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_sel_q   <= bus_sel_d;
            bus_wdata_q <= bus_wdata_d;
            op_q        <= op_d;
            lo_q        <= lo_d;
            wd_q        <= wd_d;
            wreg_q      <= wreg_d;
            cap_q       <= cap_d;
            cnt_q       <= cnt_d;
        end
    end

endmodule
